// File: rtl/common.sv
// Shared definitions for the flash loader: controller FSM states and default
// host/instruction-memory widths.
package common;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } flash_state_t;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_ADDR_BITS      = 11;
    localparam int DEF_RELEASE_CYCLES = 3;

endpackage

// File: rtl/flash_ctrl.sv
// Boot loader: streams host (addr, data) beats into instruction memory while
// holding the CPU in reset, then releases it and hands the memory port to fetch.
module flash_ctrl
    import common::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_valid,
    output logic                 host_ready,
    input  logic [WIDTH-1:0]     host_addr,
    input  logic [WIDTH-1:0]     host_data,
    input  logic                 host_last,
    input  logic                 reload_req,
    input  logic [WIDTH-1:0]     cpu_fetch_addr,
    output logic                 imem_we,
    output logic [ADDR_BITS-1:0] imem_addr,
    output logic [WIDTH-1:0]     imem_wdata,
    output logic                 cpu_rst,
    output logic                 boot_done,
    output logic                 load_err,
    output logic [ADDR_BITS-2:0] load_count
);

    localparam int                  HC_W      = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(RELEASE_CYCLES - 1);
    localparam logic [ADDR_BITS-2:0] COUNT_MAX = '1;

    flash_state_t         state_q, state_d;
    logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                 load_err_q, load_err_d;
    logic [ADDR_BITS-2:0] load_count_q, load_count_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 boot_done_q, boot_done_d;

    logic accept;
    logic beat_ok;
    logic we_live;
    logic unused_fetch;

    assign unused_fetch = ^cpu_fetch_addr[WIDTH-1:ADDR_BITS];

    assign accept  = host_valid && (state_q == LOAD);
    assign beat_ok = (host_addr[1:0] == 2'b00) && !(|host_addr[WIDTH-1:ADDR_BITS]);
    // A write still pending when reset arrives must never reach the memory.
    assign we_live = wr_pend_q && !rst;

    // NOTE: every next-state signal gets its hold value first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wr_pend_d    = accept && beat_ok;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_err_d   = load_err_q;
        load_count_d = load_count_q;

        if (accept && beat_ok) begin
            wr_addr_d = host_addr[ADDR_BITS-1:0];
            wr_data_d = host_data;
        end
        if (accept && !beat_ok) begin
            load_err_d = 1'b1;
        end
        if (wr_pend_q && (load_count_q != COUNT_MAX)) begin
            load_count_d = load_count_q + 1'b1;
        end

        case (state_q)
            LOAD: begin
                if (accept && host_last) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (reload_req) begin
                    state_d      = LOAD;
                    load_count_d = '0;
                    load_err_d   = 1'b0;
                end
            end
            default: state_d = LOAD;
        endcase

        cpu_rst_d   = (state_d != RUN);
        boot_done_d = (state_d == RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            hold_cnt_q   <= '0;
            wr_pend_q    <= 1'b0;
            load_err_q   <= 1'b0;
            load_count_q <= '0;
            cpu_rst_q    <= 1'b1;
            boot_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            wr_pend_q    <= wr_pend_d;
            load_err_q   <= load_err_d;
            load_count_q <= load_count_d;
            cpu_rst_q    <= cpu_rst_d;
            boot_done_q  <= boot_done_d;
        end
    end

    // NOTE: the write address/data holding registers are left unreset; they are
    // only observed while wr_pend_q is set, which reset does clear.
    always_ff @(posedge clk) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= wr_data_d;
    end

    assign host_ready = (state_q == LOAD);
    assign imem_we    = we_live;
    assign imem_addr  = we_live ? wr_addr_q : cpu_fetch_addr[ADDR_BITS-1:0];
    assign imem_wdata = we_live ? wr_data_q : '0;
    assign cpu_rst    = cpu_rst_q;
    assign boot_done  = boot_done_q;
    assign load_err   = load_err_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: a scoreboard of expected instruction-memory
// writes plus per-scenario checks of FSM timing, errors and reload behaviour.
module tb_flash_ctrl;

    localparam int WIDTH     = 32;
    localparam int ADDR_BITS = 11;

    logic                 clk;
    logic                 rst;
    logic                 host_valid;
    logic                 host_ready;
    logic [WIDTH-1:0]     host_addr;
    logic [WIDTH-1:0]     host_data;
    logic                 host_last;
    logic                 reload_req;
    logic [WIDTH-1:0]     cpu_fetch_addr;
    logic                 imem_we;
    logic [ADDR_BITS-1:0] imem_addr;
    logic [WIDTH-1:0]     imem_wdata;
    logic                 cpu_rst;
    logic                 boot_done;
    logic                 load_err;
    logic [ADDR_BITS-2:0] load_count;

    typedef struct {
        int                   cyc;
        logic [ADDR_BITS-1:0] addr;
        logic [WIDTH-1:0]     data;
    } wr_t;

    wr_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;

    flash_ctrl #(
        .WIDTH(WIDTH),
        .ADDR_BITS(ADDR_BITS),
        .RELEASE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_addr(host_addr),
        .host_data(host_data),
        .host_last(host_last),
        .reload_req(reload_req),
        .cpu_fetch_addr(cpu_fetch_addr),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst),
        .boot_done(boot_done),
        .load_err(load_err),
        .load_count(load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write pulse must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write cyc=%0d addr=%h data=%h required=no write", cyc, imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || imem_addr !== e.addr || imem_wdata !== e.data) begin
                    miscompares++;
                    $display("FAIL write cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                             cyc, imem_addr, imem_wdata, e.cyc, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic idle();
        host_valid = 1'b0;
        host_last  = 1'b0;
        host_addr  = '0;
        host_data  = '0;
    endtask

    // Present one beat for one cycle; returns the cycle in which it is accepted.
    task automatic beat(input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] data,
                        input logic last, output int c);
        host_valid = 1'b1;
        host_addr  = addr;
        host_data  = data;
        host_last  = last;
        @(negedge clk);
        c = cyc;
        chk("beat_ready", {31'd0, host_ready}, 32'd1);
        if (addr[1:0] == 2'b00 && addr < (1 << ADDR_BITS))
            sb.push_back('{cyc: c + 1, addr: addr[ADDR_BITS-1:0], data: data});
        next_cycle();
    endtask

    task automatic do_reload();
        reload_req = 1'b1;
        next_cycle();
        reload_req = 1'b0;
        @(negedge clk);
        chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("reload_boot_done", {31'd0, boot_done}, 32'd0);
        chk("reload_host_ready", {31'd0, host_ready}, 32'd1);
        chk("reload_load_err", {31'd0, load_err}, 32'd0);
        chk("reload_load_count", {22'd0, load_count}, 32'd0);
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
        chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
        chk("rst_load_err", {31'd0, load_err}, 32'd0);
        chk("rst_load_count", {22'd0, load_count}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", {31'd0, host_ready}, 32'd1);
        next_cycle();
    endtask

    task automatic test_basic_load();
        int c0, c;
        beat(32'h0, 32'h00c64633, 1'b0, c0);
        beat(32'h4, 32'h00160613, 1'b0, c);
        beat(32'h8, 32'hffc00067, 1'b1, c);
        idle();
        at_cycle(c0 + 3);
        chk("basic_hold_ready", {31'd0, host_ready}, 32'd0);
        at_cycle(c0 + 4);
        chk("basic_load_count", {22'd0, load_count}, 32'd3);
        at_cycle(c0 + 5);
        chk("basic_cpu_rst_hold", {31'd0, cpu_rst}, 32'd1);
        at_cycle(c0 + 6);
        chk("basic_cpu_rst_fall", {31'd0, cpu_rst}, 32'd0);
        chk("basic_boot_done", {31'd0, boot_done}, 32'd1);
        chk("basic_load_err", {31'd0, load_err}, 32'd0);
        next_cycle();
    endtask

    task automatic test_fetch();
        logic [WIDTH-1:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'h0000_1008};
        for (int i = 0; i < 4; i++) begin
            cpu_fetch_addr = addrs[i];
            #1;
            chk("fetch_addr", {21'd0, imem_addr}, {21'd0, addrs[i][ADDR_BITS-1:0]});
            chk("fetch_we", {31'd0, imem_we}, 32'd0);
            chk("fetch_wdata", imem_wdata, 32'd0);
            next_cycle();
        end
        cpu_fetch_addr = '0;
    endtask

    task automatic test_oob_last();
        int c;
        do_reload();
        beat(32'h800, 32'h12345678, 1'b1, c);
        idle();
        at_cycle(c + 1);
        chk("oob_load_err", {31'd0, load_err}, 32'd1);
        chk("oob_hold_ready", {31'd0, host_ready}, 32'd0);
        at_cycle(c + 3);
        chk("oob_boot_done_early", {31'd0, boot_done}, 32'd0);
        at_cycle(c + 4);
        chk("oob_boot_done", {31'd0, boot_done}, 32'd1);
        chk("oob_load_count", {22'd0, load_count}, 32'd0);
        next_cycle();
    endtask

    task automatic test_reload();
        int c;
        do_reload();
        beat(32'h10, 32'h11111111, 1'b0, c);
        beat(32'h14, 32'h22222222, 1'b0, c);
        beat(32'h6, 32'hdeadbeef, 1'b0, c);
        idle();
        at_cycle(c + 2);
        chk("misalign_load_err", {31'd0, load_err}, 32'd1);
        chk("misalign_load_count", {22'd0, load_count}, 32'd2);
        next_cycle();
        reload_req = 1'b1;
        next_cycle();
        reload_req = 1'b0;
        @(negedge clk);
        chk("reload_in_load_ready", {31'd0, host_ready}, 32'd1);
        chk("reload_in_load_err", {31'd0, load_err}, 32'd1);
        chk("reload_in_load_count", {22'd0, load_count}, 32'd2);
        next_cycle();
        beat(32'h18, 32'h33333333, 1'b1, c);
        idle();
        reload_req = 1'b1;
        at_cycle(c + 3);
        reload_req = 1'b0;
        at_cycle(c + 4);
        chk("reload_in_hold_boot", {31'd0, boot_done}, 32'd1);
        chk("reload_in_hold_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("reload_new_count", {22'd0, load_count}, 32'd3);
        next_cycle();
    endtask

    task automatic test_saturate();
        int c;
        do_reload();
        for (int i = 0; i < 1030; i++)
            beat((i * 4) % 2048, $urandom, i == 1029, c);
        idle();
        at_cycle(c + 4);
        chk("sat_boot_done", {31'd0, boot_done}, 32'd1);
        chk("sat_load_count", {22'd0, load_count}, 32'd1023);
        next_cycle();
    endtask

    task automatic test_reset_abort();
        do_reload();
        host_valid = 1'b1;
        host_addr  = 32'h4;
        host_data  = 32'hcafef00d;
        host_last  = 1'b0;
        next_cycle();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_we_in_rst", {31'd0, imem_we}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_we_after", {31'd0, imem_we}, 32'd0);
        chk("abort_ready", {31'd0, host_ready}, 32'd1);
        chk("abort_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("abort_load_count", {22'd0, load_count}, 32'd0);
        repeat (2) next_cycle();
        @(negedge clk);
        chk("abort_count_later", {22'd0, load_count}, 32'd0);
        next_cycle();
    endtask

    initial begin
        rst            = 1'b1;
        reload_req     = 1'b0;
        cpu_fetch_addr = '0;
        idle();
        test_reset();
        test_basic_load();
        test_fetch();
        test_oob_last();
        test_reload();
        test_saturate();
        test_reset_abort();
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
